bus_gearbox_fifo: RTL and testbench
===================================

Name: bus_gearbox_fifo

Overview:
- Parametrised wide-to-narrow bus FIFO. Each write pushes up to RATIO narrow lanes of OUT_W bits. Each read pops one OUT_W word.
- Generalises the fixed 128-to-64 bus FIFO:
  - configurable width ratio and depth;
  - partial-lane writes;
  - space-checked write acceptance;
  - programmable almost-full threshold;
  - read-valid strobe and occupancy output;
  - sticky overflow/underflow error flags.
- Sits between the wide burst-master data path and narrow consumers such as the SHA3 absorb datapath.

Parameters:
- OUT_W, 64, read word width in bits; also the lane width.
- RATIO, 2, lanes per write word; write width IN_W = OUT_W*RATIO; power of two, 1..8.
- DEPTH, 32, storage in OUT_W words; power of two; must be >= 2*RATIO.
- AFULL_TH, 16, fifo_almost_full asserts when level >= AFULL_TH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- write_en  in  1  write request.
- write_lanes  in  $clog2(RATIO)+1  number of valid lanes in this write, 0..RATIO.
- write_data  in  IN_W  lane k = bits [k*OUT_W +: OUT_W]; lane 0 is enqueued first.
- read_en  in  1  read request.
- clear_err  in  1  clears the sticky error flags.
- read_data  out  OUT_W  registered pop data.
- read_valid  out  1  pulses for one cycle when read_data carries newly popped data.
- level  out  $clog2(DEPTH)+1  current occupancy in OUT_W words.
- fifo_full  out  1  high when free space < RATIO (a full-width write cannot be guaranteed).
- fifo_almost_full  out  1  high when level >= AFULL_TH.
- fifo_empty  out  1  high when level == 0.
- overflow  out  1  sticky error flag.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high, while rst=1 on a clock edge):
  - wr_ptr, rd_ptr and level go to 0.
  - read_data = 0; read_valid = 0; overflow = 0; underflow = 0.
  - Memory contents are not cleared.
  - Reset overrides every request in the same cycle, including mid-stream traffic; nothing is accepted on that edge.
- free = DEPTH - level. All acceptance checks use the registered level from the start of the cycle. There is no same-cycle bypass: a read in the same cycle does not create room for a write.
- Write acceptance:
  - A write is accepted when write_en=1, 1 <= write_lanes <= RATIO, and write_lanes <= free.
  - On accept, lanes 0..write_lanes-1 are stored at wr_ptr, wr_ptr+1, ... modulo DEPTH, and wr_ptr advances by write_lanes modulo DEPTH.
  - Lanes at index >= write_lanes are ignored.
  - Wrap-around mid-write is legal; address arithmetic is done in $clog2(DEPTH) bits.
- Write rejection:
  - write_en=1 with write_lanes > free, or write_lanes > RATIO: nothing is stored, pointers are unchanged, and overflow is set.
  - write_en=1 with write_lanes = 0 is a no-op and not an error.
- Read:
  - A read is accepted when read_en=1 and level > 0.
  - On accept: read_data <= mem[rd_ptr], rd_ptr <= rd_ptr+1 modulo DEPTH, and read_valid = 1 on the following cycle.
  - Read latency is one cycle.
  - read_en=1 with level = 0 sets underflow. read_data and rd_ptr hold and read_valid stays 0.
  - read_data holds its last value whenever no read is accepted.
- Level update: level_next = level + accepted_write_lanes - accepted_read. Both can happen in the same cycle; level never exceeds DEPTH and never goes below 0.
- Flags:
  - fifo_full, fifo_almost_full and fifo_empty are combinational from the registered level.
  - fifo_full implies a RATIO-lane write will be rejected. Partial writes may still succeed while fifo_full=1, if write_lanes <= free.
- Error flags:
  - overflow and underflow are sticky until clear_err=1 or reset.
  - If clear_err and a new error occur in the same cycle, the flag ends set (set wins).
- No internal state machine beyond the pointer, level and flag registers. The block is fully pipelined: one write and one read can be accepted every cycle.

Test Plan:
- Full-width streaming, defaults:
  - Stimulus: write {64'h1111, 64'h0000} with lanes=2, then {64'h3333, 64'h2222} with lanes=2; then read 4 times.
  - Required: read_data sequence 0000, 1111, 2222, 3333, each one cycle after its read_en, with read_valid high for each.
  - Required: level goes 2, 4, then falls 3, 2, 1, 0; fifo_empty=1 at the end.
- Partial lanes and wrap:
  - Stimulus: fill 31 words using 15 writes of 2 lanes plus 1 write of 1 lane; read 4 times; write 2 lanes {B, A}.
  - Required: wr_ptr wraps across 31→0, with A stored at address 31 and B at address 0.
  - Required: subsequent reads return the stored data in order, with the A-to-B sequence preserved across the wrap.
- Full boundary:
  - Stimulus: reach level=31, then write lanes=2.
  - Required: write rejected, level stays 31, overflow=1, fifo_full=1.
  - Stimulus: then write lanes=1.
  - Required: write accepted, level=32.
- Simultaneous read and write:
  - Stimulus: at level=30, write lanes=2 and read in the same cycle.
  - Required: level=31, read_valid=1 next cycle.
  - Stimulus: at level=31, write lanes=2 and read in the same cycle.
  - Required: write rejected (no bypass), level=30, overflow=1.
- Empty boundary:
  - Stimulus: read_en while empty.
  - Required: underflow=1, read_valid=0, read_data unchanged.
  - Stimulus: clear_err for one cycle.
  - Required: flags return to 0.
  - Stimulus: clear_err together with a new empty read.
  - Required: underflow stays 1.
- Reset mid-stream and almost-full:
  - Stimulus: at level=20, assert rst together with write_en and read_en.
  - Required: next cycle level=0, fifo_empty=1, read_data=0, read_valid=0, no data accepted.
  - Stimulus: refill to level 16.
  - Required: fifo_almost_full=1 exactly when level reaches 16.

Source files
------------

// File: rtl/bus_gearbox_fifo_if.sv
// Wide-write / narrow-read FIFO bus: write side carries up to RATIO lanes, read side one lane.
// The master drives requests and the slave (the FIFO) returns data, occupancy and status flags.
interface bus_gearbox_fifo_if #(
   parameter int OUT_W = 64,
   parameter int RATIO = 2,
   parameter int DEPTH = 32
);
   localparam int IN_W = OUT_W * RATIO;
   localparam int LW   = $clog2(RATIO) + 1;
   localparam int CW   = $clog2(DEPTH) + 1;

   logic             write_en;
   logic [LW-1:0]    write_lanes;
   logic [IN_W-1:0]  write_data;
   logic             read_en;
   logic             clear_err;
   logic [OUT_W-1:0] read_data;
   logic             read_valid;
   logic [CW-1:0]    level;
   logic             fifo_full;
   logic             fifo_almost_full;
   logic             fifo_empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output write_en, write_lanes, write_data, read_en, clear_err,
      input  read_data, read_valid, level, fifo_full, fifo_almost_full,
             fifo_empty, overflow, underflow
   );

   modport slave (
      input  write_en, write_lanes, write_data, read_en, clear_err,
      output read_data, read_valid, level, fifo_full, fifo_almost_full,
             fifo_empty, overflow, underflow
   );
endinterface

// File: rtl/bus_gearbox_fifo.sv
// Wide-to-narrow gearbox FIFO: writes push 1..RATIO lanes, reads pop one lane; 1-cycle registered read.
// No backpressure stall: writes lacking space and reads while empty are dropped and raise sticky error flags.
module bus_gearbox_fifo #(
   parameter int OUT_W    = 64,
   parameter int RATIO    = 2,
   parameter int DEPTH    = 32,
   parameter int AFULL_TH = 16
) (
   input  logic              clk,
   input  logic              rst,
   bus_gearbox_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [OUT_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    level_q, level_d;
   logic [OUT_W-1:0] read_data_q, read_data_d;
   logic             read_valid_q, read_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic [CW-1:0]    free;
   logic [CW-1:0]    lanes_ext;
   logic             lanes_legal;
   logic             wr_acc;
   logic             wr_err;
   logic             rd_acc;
   logic             rd_err;
   logic [RATIO-1:0] lane_we;
   logic [AW-1:0]    lane_addr [RATIO];

   // Acceptance looks only at the registered level: a same-cycle pop never makes room for a push.
   always_comb begin
      free        = CW'(DEPTH) - level_q;
      lanes_ext   = CW'(bus.write_lanes);
      lanes_legal = (lanes_ext != '0) && (lanes_ext <= CW'(RATIO));
      wr_acc      = bus.write_en && lanes_legal && (lanes_ext <= free);
      wr_err      = bus.write_en && (lanes_ext != '0) && !wr_acc;
      rd_acc      = bus.read_en && (level_q != '0);
      rd_err      = bus.read_en && (level_q == '0);
   end

   always_comb begin
      for (int k = 0; k < RATIO; k++) begin
         lane_addr[k] = wr_ptr_q + AW'(k);
         lane_we[k]   = wr_acc && (lanes_ext > CW'(k));
      end
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      level_d      = level_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(bus.write_lanes);
      end
      if (rd_acc) begin
         rd_ptr_d     = rd_ptr_q + AW'(1);
         read_data_d  = mem_q[rd_ptr_q];
         read_valid_d = 1'b1;
      end
      level_d = level_q + (wr_acc ? lanes_ext : '0) - CW'(rd_acc);

      // A new error in the same cycle as clear_err leaves the flag set.
      overflow_d  = (overflow_q  && !bus.clear_err) || wr_err;
      underflow_d = (underflow_q && !bus.clear_err) || rd_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage is never cleared; reset only blocks the write on its own edge.
   always_ff @(posedge clk) begin
      for (int k = 0; k < RATIO; k++) begin
         if (!rst && lane_we[k]) begin
            mem_q[lane_addr[k]] <= bus.write_data[k*OUT_W +: OUT_W];
         end
      end
   end

   assign bus.read_data        = read_data_q;
   assign bus.read_valid       = read_valid_q;
   assign bus.level            = level_q;
   assign bus.fifo_full        = free < CW'(RATIO);
   assign bus.fifo_almost_full = level_q >= CW'(AFULL_TH);
   assign bus.fifo_empty       = level_q == '0;
   assign bus.overflow         = overflow_q;
   assign bus.underflow        = underflow_q;
endmodule

// File: tb/tb_bus_gearbox_fifo.sv
// Bench for bus_gearbox_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_bus_gearbox_fifo;
   localparam int OUT_W    = 64;
   localparam int RATIO    = 2;
   localparam int DEPTH    = 32;
   localparam int AFULL_TH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_gearbox_fifo_if #(.OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH)) bif ();

   bus_gearbox_fifo #(
      .OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [63:0] mq[$];
   logic [63:0] exp_q[$];
   logic [63:0] m_rd   = '0;
   bit          m_rv   = 1'b0;
   bit          m_ovf  = 1'b0;
   bit          m_udf  = 1'b0;
   bit          m_init = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
   endtask

   // FIFO as a plain queue: size is the level, pops from the front, pushes lanes to the back.
   task automatic model_step(input bit we, input int lanes, input logic [127:0] wd,
                             input bit re, input bit ce, input bit r);
      int lvl;
      bit w_ok;
      bit r_ok;
      if (r) begin
         mq.delete();
         exp_q.delete();
         m_rd   = '0;
         m_rv   = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
         m_init = 1'b1;
      end else begin
         lvl  = mq.size();
         w_ok = we && lanes >= 1 && lanes <= RATIO && lanes <= DEPTH - lvl;
         r_ok = re && lvl > 0;
         m_rv = r_ok;
         if (r_ok) begin
            m_rd = mq.pop_front();
            exp_q.push_back(m_rd);
         end
         if (w_ok) for (int k = 0; k < lanes; k++) mq.push_back(wd[k*64 +: 64]);
         m_ovf = (m_ovf && !ce) || (we && lanes != 0 && !w_ok);
         m_udf = (m_udf && !ce) || (re && lvl == 0);
      end
   endtask

   task automatic cyc(input bit we, input int lanes, input logic [127:0] wd,
                      input bit re, input bit ce, input bit r);
      bif.write_en    = we;
      bif.write_lanes = 2'(lanes);
      bif.write_data  = wd;
      bif.read_en     = re;
      bif.clear_err   = ce;
      rst             = r;
      @(posedge clk);
      model_step(we, lanes, wd, re, ce, r);
      #1;
   endtask

   task automatic wr(input int lanes, input logic [127:0] wd);
      cyc(1'b1, lanes, wd, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd();
      cyc(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle compare status against the model; popped data against the scoreboard.
   always @(negedge clk) begin
      if (m_init) begin
         chk("level", 64'(bif.level), 64'(mq.size()));
         chk("fifo_empty", 64'(bif.fifo_empty), 64'(mq.size() == 0));
         chk("fifo_full", 64'(bif.fifo_full), 64'((DEPTH - mq.size()) < RATIO));
         chk("fifo_almost_full", 64'(bif.fifo_almost_full), 64'(mq.size() >= AFULL_TH));
         chk("overflow", 64'(bif.overflow), 64'(m_ovf));
         chk("underflow", 64'(bif.underflow), 64'(m_udf));
         chk("read_valid", 64'(bif.read_valid), 64'(m_rv));
         if (bif.read_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL rd_data: read_valid=1 with no pop outstanding at %0t", $time);
            end else begin
               chk("rd_data", bif.read_data, exp_q.pop_front());
            end
         end else begin
            chk("rd_hold", bif.read_data, m_rd);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] s_exp [4];
      logic [63:0] last;
      s_exp = '{64'h0000, 64'h1111, 64'h2222, 64'h3333};

      cyc(0, 0, '0, 0, 0, 1);
      cyc(0, 0, '0, 0, 0, 1);
      chk("rst_level", 64'(bif.level), 64'd0);
      chk("rst_empty", 64'(bif.fifo_empty), 64'd1);
      chk("rst_rdata", bif.read_data, 64'd0);
      chk("rst_rvalid", 64'(bif.read_valid), 64'd0);
      chk("rst_flags", {62'd0, bif.overflow, bif.underflow}, 64'd0);

      // Full-width streaming
      wr(2, {64'h1111, 64'h0000});
      chk("s_lvl_w1", 64'(bif.level), 64'd2);
      wr(2, {64'h3333, 64'h2222});
      chk("s_lvl_w2", 64'(bif.level), 64'd4);
      for (int i = 0; i < 4; i++) begin
         rd();
         chk("s_rdata", bif.read_data, s_exp[i]);
         chk("s_rvalid", 64'(bif.read_valid), 64'd1);
         chk("s_lvl_rd", 64'(bif.level), 64'(3 - i));
      end
      chk("s_empty", 64'(bif.fifo_empty), 64'd1);

      // Partial lanes and wrap: A lands at the last slot, B at slot 0
      cyc(0, 0, '0, 0, 0, 1);
      for (int i = 0; i < 15; i++) wr(2, {64'(2*i + 1), 64'(2*i)});
      wr(1, {64'hdead_beef, 64'd30});
      chk("w_lvl31", 64'(bif.level), 64'd31);
      repeat (4) rd();
      wr(2, {64'hBBBB, 64'hAAAA});
      chk("w_lvl29", 64'(bif.level), 64'd29);
      for (int i = 0; i < 27; i++) begin
         rd();
         chk("w_order", bif.read_data, 64'(4 + i));
      end
      rd();
      chk("w_a", bif.read_data, 64'hAAAA);
      rd();
      chk("w_b", bif.read_data, 64'hBBBB);

      // Full boundary
      for (int i = 0; i < 15; i++) wr(2, {64'(100 + 2*i + 1), 64'(100 + 2*i)});
      wr(1, {64'h0, 64'd130});
      chk("f_lvl31", 64'(bif.level), 64'd31);
      wr(2, {64'hF1, 64'hF0});
      chk("f_rej_lvl", 64'(bif.level), 64'd31);
      chk("f_rej_ovf", 64'(bif.overflow), 64'd1);
      chk("f_rej_full", 64'(bif.fifo_full), 64'd1);
      wr(1, {64'h0, 64'hF2});
      chk("f_acc_lvl", 64'(bif.level), 64'd32);

      // Simultaneous read and write
      cyc(0, 0, '0, 0, 1, 0);
      rd();
      rd();
      chk("rw_lvl30", 64'(bif.level), 64'd30);
      cyc(1, 2, {64'hE1, 64'hE0}, 1, 0, 0);
      chk("rw_lvl31", 64'(bif.level), 64'd31);
      chk("rw_rvalid", 64'(bif.read_valid), 64'd1);
      cyc(1, 2, {64'hE3, 64'hE2}, 1, 0, 0);
      chk("rw_nobypass_lvl", 64'(bif.level), 64'd30);
      chk("rw_nobypass_ovf", 64'(bif.overflow), 64'd1);

      // Empty boundary
      repeat (30) rd();
      chk("e_lvl0", 64'(bif.level), 64'd0);
      last = m_rd;
      rd();
      chk("e_udf", 64'(bif.underflow), 64'd1);
      chk("e_rvalid", 64'(bif.read_valid), 64'd0);
      chk("e_rdata_hold", bif.read_data, last);
      cyc(0, 0, '0, 0, 1, 0);
      chk("e_clr", {62'd0, bif.overflow, bif.underflow}, 64'd0);
      cyc(0, 0, '0, 1, 1, 0);
      chk("e_set_wins", 64'(bif.underflow), 64'd1);

      // Reset mid-stream, then almost-full threshold
      cyc(0, 0, '0, 0, 1, 0);
      for (int i = 0; i < 10; i++) wr(2, {64'(200 + 2*i + 1), 64'(200 + 2*i)});
      chk("r_lvl20", 64'(bif.level), 64'd20);
      cyc(1, 2, {64'hC1, 64'hC0}, 1, 0, 1);
      chk("r_lvl0", 64'(bif.level), 64'd0);
      chk("r_empty", 64'(bif.fifo_empty), 64'd1);
      chk("r_rdata", bif.read_data, 64'd0);
      chk("r_rvalid", 64'(bif.read_valid), 64'd0);
      for (int i = 1; i <= 16; i++) begin
         wr(1, {64'h0, 64'(300 + i)});
         chk("af_lvl", 64'(bif.level), 64'(i));
         chk("af_flag", 64'(bif.fifo_almost_full), 64'(i >= AFULL_TH));
      end

      // Random traffic alternating write-heavy and read-heavy phases
      for (int n = 0; n < 2000; n++) begin
         bit          we, re, ce, r;
         int          lanes;
         logic [127:0] wd;
         int          rd_pct;
         rd_pct = ((n / 250) % 2 == 1) ? 70 : 30;
         we    = $urandom_range(0, 99) < 60;
         lanes = $urandom_range(0, 3);
         wd    = {$urandom, $urandom, $urandom, $urandom};
         re    = $urandom_range(0, 99) < rd_pct;
         ce    = $urandom_range(0, 19) == 0;
         r     = $urandom_range(0, 299) == 0;
         cyc(we, lanes, wd, re, ce, r);
      end

      repeat (3) cyc(0, 0, '0, 0, 0, 0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
